mem_access_unit: RTL and testbench

//   MEM-stage load/store unit for the pipelined core. Replaces the word-only

---
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: sizes and aligns accesses onto a 32-bit word bus,
// stalls the pipeline across MIO wait states, and extends load data.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_op,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              resp_valid,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                mis_q, mis_d;
  logic                we_q, we_d;
  logic [1:0]          op_q, op_d;
  logic                sign_q, sign_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-3:0]   waddr_q, waddr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                busy;

  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] off);
    case (op)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] op, input logic [1:0] off);
    case (op)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] op, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (op)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mis_d   = 1'b0;
    we_d    = we_q;
    op_d    = op_q;
    sign_d  = sign_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_op, req_addr[1:0])) begin
            mis_d = 1'b1;
          end else begin
            we_d    = req_we;
            op_d    = req_op;
            sign_d  = req_sign;
            off_d   = req_addr[1:0];
            waddr_d = req_addr[ADDR_W-1:2];
            be_d    = lane_mask(req_op, req_addr[1:0]);
            wdata_d = replicate(req_op, req_wdata);
            cnt_d   = '0;
            err_d   = 1'b0;
            stall   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ready) begin
          rdata_d = extend_load(op_q, sign_q, off_q, bus_rdata);
          state_d = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LIMIT) begin
          // Ready wins over timeout when both land on the same edge.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    op_q    <= op_d;
    sign_q  <= sign_d;
    off_q   <= off_d;
    waddr_q <= waddr_d;
    be_q    <= be_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  // Data registers are unreset; outputs are gated by state so they read 0 outside use.
  assign busy       = (state_q == BUSY);
  assign bus_req    = busy;
  assign bus_we     = busy & we_q;
  assign bus_be     = busy ? be_q : 4'b0000;
  assign bus_addr   = busy ? {waddr_q, 2'b00} : '0;
  assign bus_wdata  = (busy && we_q) ? wdata_q : 32'b0;
  assign resp_valid = (state_q == RESP) && !err_q;
  assign bus_err    = (state_q == RESP) && err_q;
  assign rdata      = (state_q == RESP) ? rdata_q : 32'b0;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-transaction timeline model plus directed literal checks.
module tb_mem_access_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, req_sign, bus_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata, bus_rdata;
  logic        stall, resp_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .rdata(rdata), .resp_valid(resp_valid), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        chk_en;
  logic        e_stall, e_req, e_we, e_resp, e_err, e_mis, e_wchk, e_rchk;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_rdata;

  logic [31:0] got_rdata, got_addr, got_wdata;
  logic [3:0]  got_be;
  logic        got_resp, got_err, got_mis;
  int          stall_cnt, busreq_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(e_stall));
      check("bus_req", 32'(bus_req), 32'(e_req));
      check("bus_we", 32'(bus_we), 32'(e_we));
      check("bus_be", 32'(bus_be), 32'(e_be));
      check("bus_addr", bus_addr, e_addr);
      check("resp_valid", 32'(resp_valid), 32'(e_resp));
      check("bus_err", 32'(bus_err), 32'(e_err));
      check("misalign", 32'(misalign), 32'(e_mis));
      if (e_wchk) check("bus_wdata", bus_wdata, e_wdata);
      if (e_rchk) check("rdata", rdata, e_rdata);
    end
  end

  function automatic int size_of(input logic [1:0] op);
    return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] op, input logic [31:0] a);
    return (int'(a & 32'h3) % size_of(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] op, input logic [31:0] a);
    int v;
    v = ((1 << size_of(op)) - 1) << int'(a & 32'h3);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] op, input logic [31:0] wd);
    int s;
    s = size_of(op);
    if (s == 1) return {24'b0, wd[7:0]} * 32'h01010101;
    if (s == 2) return {16'b0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] op, input logic sgn,
                                         input logic [31:0] a, input logic [31:0] rd);
    int s;
    logic [31:0] v, mask;
    s = size_of(op);
    if (s == 4) return rd;
    v    = rd >> (8 * int'(a & 32'h3));
    mask = (32'h1 << (8 * s)) - 32'h1;
    v    = v & mask;
    if (sgn && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic zero_exp();
    {e_stall, e_req, e_we, e_resp, e_err, e_mis, e_wchk, e_rchk} = '0;
    e_be = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (stall) stall_cnt++;
    if (bus_req) begin
      busreq_cnt++;
      got_be = bus_be; got_addr = bus_addr; got_wdata = bus_wdata;
    end
    if (resp_valid) got_resp = 1'b1;
    if (bus_err) got_err = 1'b1;
    if (resp_valid || bus_err) got_rdata = rdata;
    if (misalign) got_mis = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_req();
    req_we = 1'($urandom); req_op = 2'($urandom); req_sign = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    scramble_req();
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    zero_exp();
    tick();
  endtask

  task automatic access(input logic we, input logic [1:0] op, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input logic [31:0] rd, input int rst_at);
    logic mis, tout;
    got_rdata = 'x; got_addr = '0; got_wdata = '0; got_be = '0;
    got_resp = 0; got_err = 0; got_mis = 0; stall_cnt = 0; busreq_cnt = 0;
    mis = m_mis(op, addr);
    tout = 1'b0;
    req_valid = 1'b1; req_we = we; req_op = op; req_sign = sgn;
    req_addr = addr; req_wdata = wd;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    zero_exp();
    e_stall = !mis;
    tick();
    if (mis) begin
      req_valid = 1'b0;
      zero_exp();
      e_mis = 1'b1;
      tick();
      return;
    end
    for (int i = 0; ; i++) begin
      scramble_req();
      bus_ready = (i == delay);
      bus_rdata = (i == delay) ? rd : $urandom;
      zero_exp();
      e_stall = 1'b1; e_req = 1'b1; e_we = we; e_be = m_be(op, addr);
      e_addr = addr & ~32'h3; e_wdata = m_wdata(op, wd); e_wchk = we;
      if (i == rst_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        return;
      end
      tick();
      if (i == delay) break;
      if (i + 1 == TMO) begin
        tout = 1'b1;
        break;
      end
    end
    scramble_req();
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    zero_exp();
    e_resp = !tout; e_err = tout;
    e_rchk = tout || !we;
    e_rdata = tout ? 32'h0 : m_load(op, sgn, addr, rd);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; bus_ready = 1'b0; bus_rdata = '0;
    req_we = 0; req_op = 0; req_sign = 0; req_addr = 0; req_wdata = 0;
    chk_en = 1'b0;
    zero_exp();
    tick(); tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    idle();

    // T1: sw with zero wait
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 0, 32'h0, -1);
    check("t1_be", 32'(got_be), 32'hF);
    check("t1_addr", got_addr, 32'h100);
    check("t1_wdata", got_wdata, 32'h12345678);
    check("t1_busreq_cycles", busreq_cnt, 1);
    check("t1_stall_cycles", stall_cnt, 2);
    check("t1_resp", 32'(got_resp), 1);
    idle();

    // T2: lb signed and unsigned
    access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FF7F01, -1);
    check("t2_lb_signed", got_rdata, 32'hFFFFFF80);
    check("t2_be", 32'(got_be), 32'h8);
    access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF7F01, -1);
    check("t2_lbu", got_rdata, 32'h00000080);

    // T3: sh upper half
    access(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 1, 32'h0, -1);
    check("t3_be", 32'(got_be), 32'hC);
    check("t3_wdata", got_wdata, 32'hABCDABCD);
    check("t3_addr", got_addr, 32'h100);

    // T4: misaligned word and half
    access(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, -1);
    check("t4_lw_mis", 32'(got_mis), 1);
    check("t4_lw_busreq", busreq_cnt, 0);
    check("t4_lw_stall", stall_cnt, 0);
    access(1'b0, 2'd1, 1'b1, 32'h103, 32'h0, 0, 32'h0, -1);
    check("t4_lh_mis", 32'(got_mis), 1);
    check("t4_lh_busreq", busreq_cnt, 0);

    // T5: wait states and timeout
    access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 3, 32'hDEADBEEF, -1);
    check("t5_stall_cycles", stall_cnt, 5);
    check("t5_rdata", got_rdata, 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 100, 32'h0, -1);
    check("t5_timeout_err", 32'(got_err), 1);
    check("t5_timeout_busy", busreq_cnt, TMO);
    check("t5_timeout_rdata", got_rdata, 32'h0);
    check("t5_timeout_resp", 32'(got_resp), 0);

    // T6: reset during BUSY, then sb @0x1
    access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 10, 32'h0, 1);
    idle();
    idle();
    check("t6_no_resp", 32'(got_resp | got_err), 0);
    access(1'b1, 2'd0, 1'b0, 32'h1, 32'h5A, 0, 32'h0, -1);
    check("t6_sb_be", 32'(got_be), 32'h2);
    check("t6_sb_wdata", got_wdata, 32'h5A5A5A5A);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
             $urandom_range(0, 6), $urandom, -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
